// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way set-associative cache.
// Modules recompute field widths from their own parameters.
// The *_W values below describe the default build.
package cache_pkg;

    typedef enum logic [1:0] {
        S_COMPARE = 2'd0,
        S_WB      = 2'd1,
        S_REFILL  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 30;
    localparam int DEF_WORD_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_SETS       = 4;

    localparam int OFF_W  = $clog2(DEF_LINE_WORDS);
    localparam int IDX_W  = $clog2(DEF_SETS);
    localparam int TAG_W  = DEF_ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = DEF_WORD_W * DEF_LINE_WORDS;

endpackage

// File: rtl/cache_way.sv
// One way of the cache.
// Holds valid/dirty/tag/data for every set, exposes the entry selected by idx,
// and signals a tag match for the same entry.
// Word writes mark the entry dirty. A line install makes it valid and clean.
module cache_way #(
    parameter int SETS       = 4,
    parameter int LINE_WORDS = 4,
    parameter int WORD_W     = 32,
    parameter int TAG_BITS   = 26,
    parameter int IDX_BITS   = $clog2(SETS),
    parameter int OFF_BITS   = $clog2(LINE_WORDS),
    parameter int LINE_BITS  = WORD_W * LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [TAG_BITS-1:0]  tag,
    output logic                 hit,
    output logic                 valid,
    output logic                 dirty,
    output logic [TAG_BITS-1:0]  tag_out,
    output logic [LINE_BITS-1:0] line_out,
    input  logic                 word_we,
    input  logic [OFF_BITS-1:0]  word_off,
    input  logic [WORD_W-1:0]    word_data,
    input  logic                 line_we,
    input  logic [LINE_BITS-1:0] line_data
);

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [LINE_BITS-1:0] data_q [SETS];

    // Status bits are reset so that the whole cache is invalid after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage.
    // These need no reset because every entry is gated by valid.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][word_off*WORD_W +: WORD_W] <= word_data;
        end
    end

    // Read out the indexed entry and compare its tag.
    always_comb begin
        valid    = valid_q[idx];
        dirty    = dirty_q[idx];
        tag_out  = tag_q[idx];
        line_out = data_q[idx];
        hit      = valid_q[idx] && (tag_q[idx] == tag);
    end

endmodule

// File: rtl/cache_2way.sv
// Write-back, write-allocate, 2-way set-associative processor cache.
// Provides a zero-latency hit path and per-set LRU victim choice.
// Has a three-state miss FSM (compare / write-back / refill) and saturating
// hit and miss counters.
module cache_2way
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 30,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 4,
    parameter int CNT_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 proc_reset_n,
    input  logic                                 proc_read,
    input  logic                                 proc_write,
    input  logic [ADDR_W-1:0]                    proc_addr,
    input  logic [WORD_W-1:0]                    proc_wdata,
    output logic [WORD_W-1:0]                    proc_rdata,
    output logic                                 proc_stall,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_W-$clog2(LINE_WORDS)-1:0] mem_addr,
    output logic [WORD_W*LINE_WORDS-1:0]         mem_wdata,
    input  logic [WORD_W*LINE_WORDS-1:0]         mem_rdata,
    input  logic                                 mem_ready,
    output logic [CNT_W-1:0]                     hit_cnt,
    output logic [CNT_W-1:0]                     miss_cnt
);

    localparam int OFF_BITS  = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(SETS);
    localparam int TAG_BITS  = ADDR_W - OFF_BITS - IDX_BITS;
    localparam int LINE_BITS = WORD_W * LINE_WORDS;

    logic [OFF_BITS-1:0] req_off;
    logic [IDX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0] req_tag;
    logic                req;

    state_t state, state_nx;

    logic [1:0]           way_hit;
    logic [1:0]           way_valid;
    logic [1:0]           way_dirty;
    logic [TAG_BITS-1:0]  way_tag  [2];
    logic [LINE_BITS-1:0] way_line [2];
    logic [1:0]           word_we;
    logic [1:0]           line_we;

    logic                 hit_any;
    logic                 hit_way;
    logic                 victim_sel;
    logic                 victim_q;
    logic                 refill_done;
    logic [LINE_BITS-1:0] hit_line;
    logic [SETS-1:0]      lru_q;

    assign req_off = proc_addr[OFF_BITS-1:0];
    assign req_idx = proc_addr[OFF_BITS +: IDX_BITS];
    assign req_tag = proc_addr[ADDR_W-1 -: TAG_BITS];
    assign req     = proc_read | proc_write;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .WORD_W     (WORD_W),
            .TAG_BITS   (TAG_BITS)
        ) u_way (
            .clk       (clk),
            .rst_n     (proc_reset_n),
            .idx       (req_idx),
            .tag       (req_tag),
            .hit       (way_hit[w]),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag_out   (way_tag[w]),
            .line_out  (way_line[w]),
            .word_we   (word_we[w]),
            .word_off  (req_off),
            .word_data (proc_wdata),
            .line_we   (line_we[w]),
            .line_data (mem_rdata)
        );
    end

    // Lookup.
    // A hit is only recognised in S_COMPARE, so the processor stays stalled
    // for the whole of write-back and refill.
    always_comb begin
        hit_any     = req && (state == S_COMPARE) && (|way_hit);
        hit_way     = way_hit[1];
        hit_line    = way_line[hit_way];
        refill_done = (state == S_REFILL) && mem_ready;
        if (!way_valid[0]) begin
            victim_sel = 1'b0;
        end else if (!way_valid[1]) begin
            victim_sel = 1'b1;
        end else begin
            victim_sel = lru_q[req_idx];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state <= S_COMPARE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    // mem_ready only matters while a memory transaction is open.
    always_comb begin
        state_nx = state;
        case (state)
            S_COMPARE: begin
                if (req && !hit_any) begin
                    if (way_valid[victim_sel] && way_dirty[victim_sel]) begin
                        state_nx = S_WB;
                    end else begin
                        state_nx = S_REFILL;
                    end
                end
            end
            S_WB:     if (mem_ready) state_nx = S_REFILL;
            S_REFILL: if (mem_ready) state_nx = S_COMPARE;
            default:  state_nx = S_COMPARE;
        endcase
    end

    // FSM outputs.
    // Memory strobes decode straight from state, so they drop as soon as
    // reset is asserted.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        proc_rdata = '0;
        word_we    = 2'b00;
        line_we    = 2'b00;
        proc_stall = req && !hit_any;
        case (state)
            S_COMPARE: begin
                if (hit_any && proc_read && !proc_write) begin
                    proc_rdata = hit_line[req_off*WORD_W +: WORD_W];
                end
                if (hit_any && proc_write) begin
                    word_we[hit_way] = 1'b1;
                end
            end
            S_WB: begin
                mem_write = 1'b1;
                mem_addr  = {way_tag[victim_q], req_idx};
                mem_wdata = way_line[victim_q];
            end
            S_REFILL: begin
                mem_read = 1'b1;
                mem_addr = {req_tag, req_idx};
                if (mem_ready) begin
                    line_we[victim_q] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Victim latch and LRU update.
    // The LRU bit always names the way that was not just touched.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            if (state == S_COMPARE && req && !hit_any) begin
                victim_q <= victim_sel;
            end
            if (hit_any) begin
                lru_q[req_idx] <= !hit_way;
            end else if (refill_done) begin
                lru_q[req_idx] <= !victim_q;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_any && hit_cnt != {CNT_W{1'b1}}) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (state == S_COMPARE && req && !hit_any && miss_cnt != {CNT_W{1'b1}}) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule
